combo_lock_fsm: RTL and testbench



---
 rtl/combo_lock_pkg.sv | 49 ++++
 rtl/btn_edge.sv | 25 ++
 rtl/combo_lock_fsm.sv | 169 ++++++++++++++++
 tb/tb_combo_lock_fsm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// Shared encodings for the combination lock: FSM states double as the
// display driver's Selector mode codes, plus button indices and helpers.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    SEL_IDLE  = 3'b000,
    SEL_DIG1  = 3'b001,
    SEL_DIG2  = 3'b010,
    SEL_DIG3  = 3'b011,
    SEL_DIG4  = 3'b100,
    SEL_CHECK = 3'b101,
    SEL_PASS  = 3'b110,
    SEL_FAIL  = 3'b111
  } sel_e;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_ENTER = 2;
  localparam int BTN_CLEAR = 3;

  function automatic sel_e next_digit_state(input sel_e s);
    case (s)
      SEL_DIG1: return SEL_DIG2;
      SEL_DIG2: return SEL_DIG3;
      SEL_DIG3: return SEL_DIG4;
      SEL_DIG4: return SEL_CHECK;
      default:  return SEL_IDLE;
    endcase
  endfunction

  // Bit offset of digit n inside {d1,d2,d3,d4}; digit 1 is the top nibble.
  function automatic int digit_lsb(input sel_e s);
    case (s)
      SEL_DIG1: return 12;
      SEL_DIG2: return 8;
      SEL_DIG3: return 4;
      default:  return 0;
    endcase
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; emits a
// single-cycle pulse per press of an asynchronous button.
module btn_edge (
  input  logic Clock,
  input  logic Reset_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= sync_q[1];
    end
  end

  assign pulse_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/combo_lock_fsm.sv
// Combination-lock controller: collects four digits from Up/Down/Enter/Clear,
// checks them against CODE and drives the display driver's Number/Selector.
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter logic [15:0] CODE          = 16'h1234,
  parameter int unsigned CHECK_TICKS   = 50_000_000,
  parameter int unsigned RESULT_TICKS  = 200_000_000,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned LOCKOUT_TICKS = 1_000_000_000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       BtnUp,
  input  logic       BtnDown,
  input  logic       BtnEnter,
  input  logic       BtnClear,
  output logic [3:0] Number,
  output logic [2:0] Selector,
  output logic       Unlocked,
  output logic       Locked_out
);

  localparam int unsigned MAX_TICKS = max3(CHECK_TICKS, RESULT_TICKS, LOCKOUT_TICKS);
  localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int FW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;

  localparam logic [TW-1:0] CHECK_LAST   = TW'(CHECK_TICKS - 1);
  localparam logic [TW-1:0] RESULT_LAST  = TW'(RESULT_TICKS - 1);
  localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_TICKS - 1);
  localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_FAILS);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_pulse;

  assign btn_raw = {BtnClear, BtnEnter, BtnDown, BtnUp};

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_edge u_btn_edge (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .btn_i   (btn_raw[gi]),
      .pulse_o (btn_pulse[gi])
    );
  end

  logic up_p, down_p, enter_p, clear_p;
  assign up_p    = btn_pulse[BTN_UP];
  assign down_p  = btn_pulse[BTN_DOWN];
  assign enter_p = btn_pulse[BTN_ENTER];
  assign clear_p = btn_pulse[BTN_CLEAR];

  sel_e          state_q,    state_d;
  logic [3:0]    number_q,   number_d;
  logic [15:0]   digits_q,   digits_d;
  logic [FW-1:0] fail_q,     fail_d;
  logic [TW-1:0] tick_q,     tick_d;
  logic          unlocked_q, unlocked_d;
  logic          lockout_q,  lockout_d;

  logic [FW-1:0] fail_inc;
  logic          timed;

  assign fail_inc = (fail_q >= FAIL_LIMIT) ? FAIL_LIMIT : fail_q + 1'b1;
  assign timed    = (state_q == SEL_CHECK) || (state_q == SEL_PASS) || (state_q == SEL_FAIL);

  always_comb begin
    state_d   = state_q;
    number_d  = number_q;
    digits_d  = digits_q;
    fail_d    = fail_q;
    lockout_d = lockout_q;

    case (state_q)
      SEL_IDLE: begin
        number_d = 4'h0;
        if (enter_p) begin
          state_d  = SEL_DIG1;
          digits_d = 16'h0000;
        end
      end

      SEL_DIG1, SEL_DIG2, SEL_DIG3, SEL_DIG4: begin
        // Clear beats Enter beats Up/Down; Enter latches the pre-edit value.
        if (clear_p) begin
          state_d  = SEL_IDLE;
          digits_d = 16'h0000;
          number_d = 4'h0;
        end else if (enter_p) begin
          digits_d[digit_lsb(state_q) +: 4] = number_q;
          number_d = 4'h0;
          state_d  = next_digit_state(state_q);
        end else if (up_p && !down_p) begin
          number_d = number_q + 4'h1;
        end else if (down_p && !up_p) begin
          number_d = number_q - 4'h1;
        end
      end

      SEL_CHECK: begin
        number_d = 4'h0;
        if (tick_q == CHECK_LAST) begin
          if (digits_q == CODE) begin
            state_d = SEL_PASS;
            fail_d  = '0;
          end else begin
            state_d   = SEL_FAIL;
            fail_d    = fail_inc;
            lockout_d = (fail_inc == FAIL_LIMIT);
          end
        end
      end

      SEL_PASS: begin
        number_d = 4'h0;
        if (tick_q == RESULT_LAST) state_d = SEL_IDLE;
      end

      SEL_FAIL: begin
        number_d = 4'h0;
        if (lockout_q) begin
          if (tick_q == LOCKOUT_LAST) begin
            state_d   = SEL_IDLE;
            fail_d    = '0;
            lockout_d = 1'b0;
          end
        end else if (tick_q == RESULT_LAST) begin
          state_d = SEL_IDLE;
        end
      end

      default: begin
        state_d   = SEL_IDLE;
        number_d  = 4'h0;
        lockout_d = 1'b0;
      end
    endcase

    // The tick counter only runs while dwelling in a timed state.
    tick_d     = (timed && (state_d == state_q)) ? tick_q + 1'b1 : '0;
    unlocked_d = (state_d == SEL_PASS);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= SEL_IDLE;
      number_q   <= 4'h0;
      digits_q   <= 16'h0000;
      fail_q     <= '0;
      tick_q     <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      number_q   <= number_d;
      digits_q   <= digits_d;
      fail_q     <= fail_d;
      tick_q     <= tick_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
    end
  end

  assign Number     = number_q;
  assign Selector   = state_q;
  assign Unlocked   = unlocked_q;
  assign Locked_out = lockout_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed bench for combo_lock_fsm with shortened tick parameters; every
// expected value below is hand-derived from the lock's intended behaviour.
module tb_combo_lock_fsm;

  localparam logic [3:0] M_UP    = 4'b0001;
  localparam logic [3:0] M_DOWN  = 4'b0010;
  localparam logic [3:0] M_ENTER = 4'b0100;
  localparam logic [3:0] M_CLEAR = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_enter, btn_clear;
  logic [3:0] number;
  logic [2:0] selector;
  logic       unlocked, locked_out;

  int total = 0;
  int bad   = 0;

  combo_lock_fsm #(
    .CODE          (16'h1234),
    .CHECK_TICKS   (4),
    .RESULT_TICKS  (8),
    .MAX_FAILS     (2),
    .LOCKOUT_TICKS (20)
  ) dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .BtnUp      (btn_up),
    .BtnDown    (btn_down),
    .BtnEnter   (btn_enter),
    .BtnClear   (btn_clear),
    .Number     (number),
    .Selector   (selector),
    .Unlocked   (unlocked),
    .Locked_out (locked_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] sel, input logic [3:0] num,
                            input logic unl, input logic lck);
    chk({tag, ".sel"}, 16'(selector), 16'(sel));
    chk({tag, ".num"}, 16'(number), 16'(num));
    chk({tag, ".unl"}, 16'(unlocked), 16'(unl));
    chk({tag, ".lck"}, 16'(locked_out), 16'(lck));
  endtask

  // One-cycle press; returns at the negedge after the FSM has reacted.
  task automatic press(input logic [3:0] mask);
    @(posedge clk);
    #1 {btn_clear, btn_enter, btn_down, btn_up} = mask;
    @(posedge clk);
    #1 {btn_clear, btn_enter, btn_down, btn_up} = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    $display("press %b -> sel=%b num=%h unl=%b lck=%b", mask, selector, number, unlocked, locked_out);
  endtask

  task automatic enter_code(input logic [15:0] code);
    press(M_ENTER);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] nib;
      nib = code[12 - 4*d +: 4];
      for (int k = 0; k < int'(nib); k++) press(M_UP);
      chk("digit_value", 16'(number), 16'(nib));
      press(M_ENTER);
    end
  endtask

  task automatic check_phase();
    for (int i = 0; i < 4; i++) begin
      expect_out("check", 3'b101, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic result_phase(input bit pass, input bit lock);
    int n;
    n = lock ? 20 : 8;
    check_phase();
    for (int i = 0; i < n; i++) begin
      expect_out(pass ? "pass" : "fail", pass ? 3'b110 : 3'b111, 4'h0, pass, lock);
      @(negedge clk);
    end
    expect_out("back_idle", 3'b000, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    {btn_clear, btn_enter, btn_down, btn_up} = 4'b0000;
    #12;
    expect_out("reset", 3'b000, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct code, stepping through every digit state.
    press(M_ENTER);
    expect_out("dig1", 3'b001, 4'h0, 1'b0, 1'b0);
    for (int d = 1; d <= 4; d++) begin
      for (int k = 0; k < d; k++) press(M_UP);
      chk("correct_num", 16'(number), 16'(d));
      press(M_ENTER);
      expect_out("advance", 3'(d + 1), 4'h0, 1'b0, 1'b0);
    end
    result_phase(1'b1, 1'b0);

    // Wrap-around, Up+Down cancel, Enter+Up, then Clear in DIG3.
    press(M_ENTER);
    press(M_DOWN);
    chk("wrap_down", 16'(number), 16'hF);
    press(M_UP);
    chk("wrap_up", 16'(number), 16'h0);
    press(M_UP);
    press(M_UP | M_DOWN);
    chk("up_down_cancel", 16'(number), 16'h1);
    press(M_ENTER);
    for (int k = 0; k < 3; k++) press(M_UP);
    chk("dig2_num3", 16'(number), 16'h3);
    press(M_ENTER | M_UP);
    expect_out("enter_up", 3'b011, 4'h0, 1'b0, 1'b0);
    press(M_UP);
    chk("dig3_num1", 16'(number), 16'h1);
    press(M_CLEAR);
    expect_out("clear", 3'b000, 4'h0, 1'b0, 1'b0);
    press(M_UP);
    expect_out("idle_ignores_up", 3'b000, 4'h0, 1'b0, 1'b0);

    // Correct entry after Clear; digit 2 stored via Enter+Up keeps pre-edit value 2.
    press(M_ENTER);
    press(M_UP);
    press(M_ENTER);
    press(M_UP);
    press(M_UP);
    press(M_ENTER | M_UP);
    expect_out("enter_up_2", 3'b011, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) press(M_UP);
    press(M_ENTER);
    for (int k = 0; k < 4; k++) press(M_UP);
    press(M_ENTER);
    result_phase(1'b1, 1'b0);

    // Two wrong codes: plain FAIL, then lockout.
    enter_code(16'h1235);
    result_phase(1'b0, 1'b0);
    enter_code(16'h0000);
    result_phase(1'b0, 1'b1);

    // Fail count was cleared by the lockout, so one failure is not a lockout.
    enter_code(16'h1235);
    result_phase(1'b0, 1'b0);

    // Second failure locks out again; reset asynchronously mid-lockout.
    enter_code(16'h0000);
    check_phase();
    for (int i = 0; i < 5; i++) begin
      expect_out("lock_hold", 3'b111, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 expect_out("async_reset", 3'b000, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("in_reset", 3'b000, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Reset cleared the fail count too.
    enter_code(16'h4321);
    result_phase(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
